// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control unit: IF/ID/EX/MEM/WB FSM with combinational
// strobe/select decode and a retired-instruction counter.
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op_code,
  input  logic [5:0]  funct,
  input  logic        ZF,
  input  logic        mem_ready,
  output logic        PC_Write,
  output logic        IR_Write,
  output logic        Write_Reg,
  output logic        Mem_Write,
  output logic        Mem_Read,
  output logic [2:0]  ALU_OP,
  output logic [1:0]  w_r_s,
  output logic [1:0]  wr_data_s,
  output logic [1:0]  PC_s,
  output logic        imm_s,
  output logic        rt_imm_s,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    K_RALU, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_ILL
  } kind_e;

  state_e      state_q, state_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        retire;

  kind_e       kind;
  logic [2:0]  dec_alu;
  logic        dec_imm;
  logic        dec_rt_imm;

  // Instruction decode; op_code/funct come straight from the IR.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    kind       = K_ILL;
    dec_alu    = 3'b100;
    dec_imm    = 1'b0;
    dec_rt_imm = 1'b0;
    case (op_code)
      6'b000000: begin
        kind = K_RALU;
        case (funct)
          6'b100000: dec_alu = 3'b100;
          6'b100010: dec_alu = 3'b101;
          6'b100100: dec_alu = 3'b000;
          6'b100101: dec_alu = 3'b001;
          6'b100110: dec_alu = 3'b010;
          6'b100111: dec_alu = 3'b011;
          6'b101011: dec_alu = 3'b110;
          6'b000100: dec_alu = 3'b111;
          6'b001000: kind    = K_JR;
          default:   kind    = K_ILL;
        endcase
      end
      6'b001000: begin kind = K_IALU; dec_imm = 1'b1; dec_rt_imm = 1'b1; end
      6'b001100: begin kind = K_IALU; dec_alu = 3'b000; dec_rt_imm = 1'b1; end
      6'b001110: begin kind = K_IALU; dec_alu = 3'b010; dec_rt_imm = 1'b1; end
      6'b001011: begin kind = K_IALU; dec_alu = 3'b110; dec_rt_imm = 1'b1; end
      6'b100011: begin kind = K_LW;   dec_imm = 1'b1; dec_rt_imm = 1'b1; end
      6'b101011: begin kind = K_SW;   dec_imm = 1'b1; dec_rt_imm = 1'b1; end
      6'b000100: begin kind = K_BEQ;  dec_alu = 3'b101; end
      6'b000101: begin kind = K_BNE;  dec_alu = 3'b101; end
      6'b000010: kind = K_J;
      6'b000011: kind = K_JAL;
      default:   kind = K_ILL;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    PC_Write  = 1'b0;
    IR_Write  = 1'b0;
    Write_Reg = 1'b0;
    Mem_Write = 1'b0;
    Mem_Read  = 1'b0;
    illegal   = 1'b0;
    ALU_OP    = 3'b100;
    w_r_s     = 2'b00;
    wr_data_s = 2'b00;
    PC_s      = 2'b00;
    imm_s     = 1'b0;
    rt_imm_s  = 1'b0;

    // Datapath selects stay constant from EX through WB.
    if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      ALU_OP    = dec_alu;
      imm_s     = dec_imm;
      rt_imm_s  = dec_rt_imm;
      w_r_s     = (kind == K_IALU || kind == K_LW) ? 2'b01 : 2'b00;
      wr_data_s = (kind == K_LW) ? 2'b01 : 2'b00;
    end

    case (state_q)
      S_IF: begin
        Mem_Read = 1'b1;
        if (mem_ready) begin
          IR_Write = 1'b1;
          PC_Write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        case (kind)
          K_J, K_JAL: begin
            PC_Write = 1'b1;
            PC_s     = 2'b11;
            if (kind == K_JAL) begin
              Write_Reg = 1'b1;
              w_r_s     = 2'b10;
              wr_data_s = 2'b10;
            end
            retire  = 1'b1;
            state_d = S_IF;
          end
          K_JR: begin
            PC_Write = 1'b1;
            PC_s     = 2'b01;
            retire   = 1'b1;
            state_d  = S_IF;
          end
          K_ILL: begin
            illegal = 1'b1;
            state_d = S_IF;
          end
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (kind)
          K_LW, K_SW: state_d = S_MEM;
          K_BEQ, K_BNE: begin
            if ((kind == K_BEQ) == ZF) begin
              PC_Write = 1'b1;
              PC_s     = 2'b10;
            end
            retire  = 1'b1;
            state_d = S_IF;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (kind == K_LW) begin
          Mem_Read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else begin
          Mem_Write = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_IF;
          end
        end
      end
      S_WB: begin
        Write_Reg = 1'b1;
        retire    = 1'b1;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset must silence strobes even when it interrupts MEM or WB.
    if (!rst_n) begin
      PC_Write  = 1'b0;
      IR_Write  = 1'b0;
      Write_Reg = 1'b0;
      Mem_Write = 1'b0;
      Mem_Read  = 1'b0;
      illegal   = 1'b0;
    end

    instr_cnt_d = instr_cnt_q + {31'd0, retire};
  end

  // NOTE: reset is synchronous here (sampled in the clocked block), and state uses <= only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IF;
      instr_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl; inputs change and outputs
// are sampled just after the falling edge.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op_code, funct;
  logic        ZF, mem_ready;
  logic        PC_Write, IR_Write, Write_Reg, Mem_Write, Mem_Read;
  logic [2:0]  ALU_OP;
  logic [1:0]  w_r_s, wr_data_s, PC_s;
  logic        imm_s, rt_imm_s;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct(funct), .ZF(ZF),
    .mem_ready(mem_ready), .PC_Write(PC_Write), .IR_Write(IR_Write),
    .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .Mem_Read(Mem_Read),
    .ALU_OP(ALU_OP), .w_r_s(w_r_s), .wr_data_s(wr_data_s), .PC_s(PC_s),
    .imm_s(imm_s), .rt_imm_s(rt_imm_s), .state(state), .illegal(illegal),
    .instr_cnt(instr_cnt)
  );

  // Strobes packed as {PC_Write, IR_Write, Write_Reg, Mem_Write, Mem_Read}.
  logic [4:0] strobes;
  assign strobes = {PC_Write, IR_Write, Write_Reg, Mem_Write, Mem_Read};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; op_code = 6'd0; funct = 6'd0; ZF = 1'b0; mem_ready = 1'b1;
    next_cycle(); next_cycle(); #1;
    check("rst_state", state, 0);
    check("rst_cnt", instr_cnt, 0);
    check("rst_strobes", strobes, 5'b00000);
    check("rst_illegal", illegal, 0);

    // Release reset: first cycle is IF fetching.
    @(negedge clk); rst_n = 1'b1; #1;
    check("post_rst_if", state, 0);
    check("post_rst_memread", Mem_Read, 1);

    // add: 0,1,2,4,0
    op_code = 6'b000000; funct = 6'b100000; #1;
    check("add_if_strobes", strobes, 5'b11001);
    check("add_if_pcs", PC_s, 2'b00);
    next_cycle(); #1;
    check("add_id_state", state, 1);
    check("add_id_wr", Write_Reg, 0);
    next_cycle(); #1;
    check("add_ex_state", state, 2);
    check("add_ex_alu", ALU_OP, 3'b100);
    check("add_ex_wr", Write_Reg, 0);
    next_cycle(); #1;
    check("add_wb_state", state, 4);
    check("add_wb_strobes", strobes, 5'b00100);
    check("add_wb_alu", ALU_OP, 3'b100);
    next_cycle(); #1;
    check("add_done_state", state, 0);
    check("add_cnt", instr_cnt, 1);

    // lw with two wait cycles in MEM: IF ID EX MEM MEM MEM WB = 7 cycles.
    op_code = 6'b100011; funct = 6'b000000; #1;
    check("lw_if_state", state, 0);
    next_cycle(); #1;
    check("lw_id_state", state, 1);
    next_cycle(); #1;
    check("lw_ex_state", state, 2);
    check("lw_ex_ctl", {ALU_OP, imm_s, rt_imm_s}, {3'b100, 1'b1, 1'b1});
    next_cycle(); mem_ready = 1'b0; #1;
    check("lw_mem1_state", state, 3);
    check("lw_mem1_strobes", strobes, 5'b00001);
    next_cycle(); #1;
    check("lw_mem2_state", state, 3);
    check("lw_mem2_rd", Mem_Read, 1);
    next_cycle(); mem_ready = 1'b1; #1;
    check("lw_mem3_state", state, 3);
    next_cycle(); #1;
    check("lw_wb_state", state, 4);
    check("lw_wb_wr", Write_Reg, 1);
    check("lw_wb_sel", {w_r_s, wr_data_s}, {2'b01, 2'b01});
    next_cycle(); #1;
    check("lw_done_state", state, 0);
    check("lw_cnt", instr_cnt, 2);

    // beq taken (ZF=1) then bne not taken (ZF=1).
    op_code = 6'b000100; ZF = 1'b1;
    next_cycle(); next_cycle(); #1;
    check("beq_ex_state", state, 2);
    check("beq_ex_pcw", PC_Write, 1);
    check("beq_ex_pcs", PC_s, 2'b10);
    check("beq_ex_alu", ALU_OP, 3'b101);
    next_cycle(); #1;
    check("beq_done_state", state, 0);
    check("beq_cnt", instr_cnt, 3);
    op_code = 6'b000101;
    next_cycle(); next_cycle(); #1;
    check("bne_ex_state", state, 2);
    check("bne_ex_pcw", PC_Write, 0);
    next_cycle(); #1;
    check("bne_done_state", state, 0);
    check("bne_cnt", instr_cnt, 4);
    ZF = 1'b0;

    // jal resolves in ID.
    op_code = 6'b000011;
    next_cycle(); #1;
    check("jal_id_state", state, 1);
    check("jal_id_strobes", strobes, 5'b10100);
    check("jal_id_sel", {PC_s, w_r_s, wr_data_s}, {2'b11, 2'b10, 2'b10});
    next_cycle(); #1;
    check("jal_done_state", state, 0);
    check("jal_cnt", instr_cnt, 5);

    // Illegal opcode: single pulse, no strobes, count unchanged.
    op_code = 6'b111111;
    next_cycle(); #1;
    check("ill_id_pulse", illegal, 1);
    check("ill_id_strobes", strobes, 5'b00000);
    next_cycle(); #1;
    check("ill_done_state", state, 0);
    check("ill_pulse_off", illegal, 0);
    check("ill_cnt", instr_cnt, 5);

    // sw interrupted by reset in MEM.
    op_code = 6'b101011;
    next_cycle(); next_cycle(); next_cycle(); mem_ready = 1'b0; #1;
    check("sw_mem_state", state, 3);
    check("sw_mem_wr", Mem_Write, 1);
    next_cycle(); rst_n = 1'b0; #1;
    check("sw_rst_state", state, 3);
    check("sw_rst_memwr", Mem_Write, 0);
    next_cycle(); #1;
    check("sw_rst_if", state, 0);
    check("sw_rst_cnt", instr_cnt, 0);
    rst_n = 1'b1; mem_ready = 1'b1; #1;
    check("sw_rel_memread", Mem_Read, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
